wr_arria10_phy_rst_seq: RTL and testbench
=========================================

WR_ARRIA10_PHY_RST_SEQ -- requirements
Module: wr_arria10_phy_rst_seq

Interface
REQ-001 g_num_channels, 1, number of transceiver channels sequenced (legal 1..8).
REQ-002 g_analog_rst_cycles, 100, minimum clk_i cycles analog resets stay asserted.
REQ-003 g_digital_rst_cycles, 50, clk_i cycles between analog release and digital release.
REQ-004 g_ltd_stable_cycles, 1000, cycles rx_is_lockedtodata must stay high before RX digital release.
REQ-005 g_lock_timeout_cycles, 100000, cycles allowed in any lock-wait state before RX restart.
REQ-006 One clock; reset is synchronous and active-low: ports clk_i and rst_n_i.
REQ-007 clk_i  in  1  system clock.
REQ-008 rst_n_i  in  1  synchronous active-low reset.
REQ-009 pll_locked_i  in  1  TX serial PLL lock, asynchronous.
REQ-010 tx_cal_busy_i, rx_cal_busy_i  in  N each  per-channel calibration busy, asynchronous.
REQ-011 rx_is_lockedtoref_i, rx_is_lockedtodata_i  in  N each  per-channel CDR status, asynchronous.
REQ-012 chan_rst_i  in  N  per-channel soft reset request, level, active-high.
REQ-013 tx_analogreset_o, tx_digitalreset_o, rx_analogreset_o, rx_digitalreset_o  out  N each  PHY reset controls.
REQ-014 rx_set_locktoref_o, rx_set_locktodata_o  out  N each  CDR manual lock mode controls.
REQ-015 tx_ready_o, rx_ready_o  out  N each  channel datapath usable.
REQ-016 rx_relock_cnt_o  out  8*N  per-channel saturating count of RX restarts (channel i at bits 8i+7..8i).

Function
REQ-017 All asynchronous inputs SHALL pass through 2-FF synchronizers; all latencies below count from synchronizer output.
REQ-018 Each channel SHALL have independent TX and RX FSMs; channels SHALL not interact except via shared pll_locked_i.
REQ-019 TX FSM states: TX_RST -> TX_WAIT -> TX_DIG -> TX_READY.
REQ-020 TX_RST: both TX resets high; exits after g_analog_rst_cycles.
REQ-021 TX_WAIT: analog high; exits when pll_locked=1 and tx_cal_busy=0, dropping tx_analogreset_o on the transition cycle.
REQ-022 TX_DIG: exits after g_digital_rst_cycles, dropping tx_digitalreset_o; TX_READY asserts tx_ready_o.
REQ-023 pll_locked falling in TX_DIG or TX_READY SHALL return TX FSM to TX_RST next cycle.
REQ-024 RX FSM states: RX_RST -> RX_CAL -> RX_LTR -> RX_LTD -> RX_DIG -> RX_READY.
REQ-025 RX_RST: both RX resets high, set_locktoref=1, set_locktodata=0; exits after g_analog_rst_cycles.
REQ-026 RX_CAL: exits when rx_cal_busy=0, releasing rx_analogreset_o.
REQ-027 RX_LTR: exits when rx_is_lockedtoref=1; transition sets set_locktoref=0, set_locktodata=1.
REQ-028 RX_LTD: stability counter clears whenever lockedtodata=0; exits when it reaches g_ltd_stable_cycles.
REQ-029 RX_DIG: exits after g_digital_rst_cycles, releasing rx_digitalreset_o; RX_READY asserts rx_ready_o.
REQ-030 lockedtodata falling in RX_DIG or RX_READY SHALL restart RX FSM at RX_RST.
REQ-031 Timeout counter SHALL run in RX_CAL, RX_LTR, RX_LTD (reset on state entry); reaching g_lock_timeout_cycles restarts at RX_RST.
REQ-032 Every RX restart (REQ-030/031) SHALL increment rx_relock_cnt, saturating at 255; soft reset SHALL not increment it.
REQ-033 chan_rst_i high SHALL hold that channel's TX and RX FSMs in *_RST with timers cleared; sequence resumes on its falling edge.
REQ-034 Simultaneous timeout and lock-exit in same cycle: exit wins.

Reset
REQ-035 rst_n_i=0 SHALL force all FSMs to *_RST, all four reset outputs=1, set_locktoref=1, set_locktodata=0, ready=0, counters and synchronizers=0, on next clk_i edge, including mid-sequence.

Structure
REQ-036 State enumerations and counter width function (clog2 of largest cycle parameter) SHALL live in shared package wr_arria10_phy_pkg.
REQ-037 Per-channel logic SHALL be sub-module wr_arria10_phy_rst_chan, generated g_num_channels times.

Verification (params 8/4/16/64, N=2)
REQ-038 Reset release, lock inputs high, cal_busy low -> tx_ready after 8+4 (+2 sync) cycles; rx_ready after 8+16+4 (+sync) cycles.
REQ-039 Ch0 lockedtodata glitch low 1 cycle at LTD count 10 -> stability restarts, rx_ready delayed 11 cycles; ch1 unaffected.
REQ-040 lockedtoref held low -> RX restart every 64 cycles in RX_LTR; relock_cnt increments 1,2,3.
REQ-041 lockedtodata drop in RX_READY -> rx_ready_o=0 and rx_digitalreset_o=1 three cycles later; counter +1.
REQ-042 pll_locked drop -> both channels' tx_ready low; chan_rst_i[1] pulse -> only ch1 resequences, count unchanged.
REQ-043 300 forced timeouts -> rx_relock_cnt saturates at 255.

Source files
------------

// File: rtl/wr_arria10_phy_pkg.sv
// Shared types and helpers for the Arria 10 PHY reset sequencer.
package wr_arria10_phy_pkg;

  // Per-channel TX reset sequence.
  typedef enum logic [1:0] {
    TX_RST,
    TX_WAIT,
    TX_DIG,
    TX_READY
  } tx_state_e;

  // Per-channel RX reset / CDR lock sequence.
  typedef enum logic [2:0] {
    RX_RST,
    RX_CAL,
    RX_LTR,
    RX_LTD,
    RX_DIG,
    RX_READY
  } rx_state_e;

  // Saturation value of the per-channel RX restart counter.
  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  // Width of a counter able to hold (largest cycle parameter - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c,
                                            input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/wr_arria10_phy_rst_chan.sv
// One transceiver channel: input synchronizers plus independent TX and RX
// reset FSMs. Only the (already synchronized) PLL lock is shared with others.
module wr_arria10_phy_rst_chan
  import wr_arria10_phy_pkg::*;
#(
  parameter int unsigned g_analog_rst_cycles   = 100,
  parameter int unsigned g_digital_rst_cycles  = 50,
  parameter int unsigned g_ltd_stable_cycles   = 1000,
  parameter int unsigned g_lock_timeout_cycles = 100000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked,          // synchronized in the top level
  input  logic       tx_cal_busy,
  input  logic       rx_cal_busy,
  input  logic       rx_is_lockedtoref,
  input  logic       rx_is_lockedtodata,
  input  logic       chan_rst,
  output logic       tx_analogreset,
  output logic       tx_digitalreset,
  output logic       rx_analogreset,
  output logic       rx_digitalreset,
  output logic       rx_set_locktoref,
  output logic       rx_set_locktodata,
  output logic       tx_ready,
  output logic       rx_ready,
  output logic [7:0] rx_relock_cnt
);

  localparam int unsigned CW = cnt_width(g_analog_rst_cycles, g_digital_rst_cycles,
                                         g_ltd_stable_cycles, g_lock_timeout_cycles);

  // Terminal counts: a phase of P cycles ends when its counter shows P-1.
  localparam logic [CW-1:0] ANALOG_LAST  = CW'(g_analog_rst_cycles - 1);
  localparam logic [CW-1:0] DIGITAL_LAST = CW'(g_digital_rst_cycles - 1);
  localparam logic [CW-1:0] LTD_LAST     = CW'(g_ltd_stable_cycles - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(g_lock_timeout_cycles - 1);

  logic [3:0] sync_q1;
  logic [3:0] sync_q2;
  logic       tx_cal_busy_s;
  logic       rx_cal_busy_s;
  logic       lockedtoref_s;
  logic       lockedtodata_s;

  // Two-flop synchronizers for the asynchronous PHY status inputs.
  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge value of its neighbours; = here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {rx_is_lockedtodata, rx_is_lockedtoref, rx_cal_busy, tx_cal_busy};
      sync_q2 <= sync_q1;
    end
  end

  assign tx_cal_busy_s  = sync_q2[0];
  assign rx_cal_busy_s  = sync_q2[1];
  assign lockedtoref_s  = sync_q2[2];
  assign lockedtodata_s = sync_q2[3];

  // ---------------------------------------------------------------- TX ---
  tx_state_e      tx_state;
  tx_state_e      tx_state_nxt;
  logic [CW-1:0]  tx_cnt;
  logic [CW-1:0]  tx_cnt_nxt;

  // TX next state; the phase counter clears on every transition.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = '0;
    case (tx_state)
      TX_RST: begin
        if (tx_cnt == ANALOG_LAST) tx_state_nxt = TX_WAIT;
        else                       tx_cnt_nxt   = tx_cnt + 1'b1;
      end
      TX_WAIT: begin
        if (pll_locked && !tx_cal_busy_s) tx_state_nxt = TX_DIG;
      end
      TX_DIG: begin
        if (!pll_locked)                  tx_state_nxt = TX_RST;
        else if (tx_cnt == DIGITAL_LAST)  tx_state_nxt = TX_READY;
        else                              tx_cnt_nxt   = tx_cnt + 1'b1;
      end
      TX_READY: begin
        if (!pll_locked) tx_state_nxt = TX_RST;
      end
      default: tx_state_nxt = TX_RST;
    endcase
    // Soft reset parks the FSM at the start with the timer cleared.
    if (chan_rst) begin
      tx_state_nxt = TX_RST;
      tx_cnt_nxt   = '0;
    end
  end

  // TX state register; outputs are registered from the next state so they
  // change on the same edge as the state and never glitch.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_state        <= TX_RST;
      tx_cnt          <= '0;
      tx_analogreset  <= 1'b1;
      tx_digitalreset <= 1'b1;
      tx_ready        <= 1'b0;
    end else begin
      tx_state        <= tx_state_nxt;
      tx_cnt          <= tx_cnt_nxt;
      tx_analogreset  <= (tx_state_nxt == TX_RST) || (tx_state_nxt == TX_WAIT);
      tx_digitalreset <= (tx_state_nxt != TX_READY);
      tx_ready        <= (tx_state_nxt == TX_READY);
    end
  end

  // ---------------------------------------------------------------- RX ---
  rx_state_e      rx_state;
  rx_state_e      rx_state_nxt;
  logic [CW-1:0]  rx_cnt;        // reset/digital phase length or LTD stability
  logic [CW-1:0]  rx_cnt_nxt;
  logic [CW-1:0]  rx_tmr;        // lock-wait timeout, cleared on state entry
  logic [CW-1:0]  rx_tmr_nxt;
  logic           rx_restart;    // lock loss or timeout: counts as a relock

  // RX next state. In the lock-wait states a successful exit is tested
  // before the timeout so that a coincident lock wins.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = '0;
    rx_tmr_nxt   = '0;
    rx_restart   = 1'b0;
    case (rx_state)
      RX_RST: begin
        if (rx_cnt == ANALOG_LAST) rx_state_nxt = RX_CAL;
        else                       rx_cnt_nxt   = rx_cnt + 1'b1;
      end
      RX_CAL: begin
        if (!rx_cal_busy_s)              rx_state_nxt = RX_LTR;
        else if (rx_tmr == TIMEOUT_LAST) rx_restart   = 1'b1;
        else                             rx_tmr_nxt   = rx_tmr + 1'b1;
      end
      RX_LTR: begin
        if (lockedtoref_s)               rx_state_nxt = RX_LTD;
        else if (rx_tmr == TIMEOUT_LAST) rx_restart   = 1'b1;
        else                             rx_tmr_nxt   = rx_tmr + 1'b1;
      end
      RX_LTD: begin
        if (lockedtodata_s && (rx_cnt == LTD_LAST)) begin
          rx_state_nxt = RX_DIG;
        end else if (rx_tmr == TIMEOUT_LAST) begin
          rx_restart = 1'b1;
        end else begin
          rx_tmr_nxt = rx_tmr + 1'b1;
          // Any low cycle restarts the stability window.
          rx_cnt_nxt = lockedtodata_s ? rx_cnt + 1'b1 : '0;
        end
      end
      RX_DIG: begin
        if (!lockedtodata_s)             rx_restart   = 1'b1;
        else if (rx_cnt == DIGITAL_LAST) rx_state_nxt = RX_READY;
        else                             rx_cnt_nxt   = rx_cnt + 1'b1;
      end
      RX_READY: begin
        if (!lockedtodata_s) rx_restart = 1'b1;
      end
      default: rx_state_nxt = RX_RST;
    endcase
    if (rx_restart) rx_state_nxt = RX_RST;
    // Soft reset overrides everything and is not counted as a relock.
    if (chan_rst) begin
      rx_state_nxt = RX_RST;
      rx_cnt_nxt   = '0;
      rx_tmr_nxt   = '0;
      rx_restart   = 1'b0;
    end
  end

  // RX state register, saturating relock counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_state          <= RX_RST;
      rx_cnt            <= '0;
      rx_tmr            <= '0;
      rx_relock_cnt     <= '0;
      rx_analogreset    <= 1'b1;
      rx_digitalreset   <= 1'b1;
      rx_set_locktoref  <= 1'b1;
      rx_set_locktodata <= 1'b0;
      rx_ready          <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_tmr   <= rx_tmr_nxt;
      if (rx_restart && (rx_relock_cnt != RELOCK_MAX)) begin
        rx_relock_cnt <= rx_relock_cnt + 1'b1;
      end
      rx_analogreset    <= (rx_state_nxt == RX_RST) || (rx_state_nxt == RX_CAL);
      rx_digitalreset   <= (rx_state_nxt != RX_READY);
      rx_set_locktoref  <= (rx_state_nxt == RX_RST) || (rx_state_nxt == RX_CAL) ||
                           (rx_state_nxt == RX_LTR);
      rx_set_locktodata <= (rx_state_nxt == RX_LTD) || (rx_state_nxt == RX_DIG) ||
                           (rx_state_nxt == RX_READY);
      rx_ready          <= (rx_state_nxt == RX_READY);
    end
  end

endmodule

// File: rtl/wr_arria10_phy_rst_seq.sv
// Arria 10 transceiver reset sequencer: synchronizes the shared TX PLL lock
// and instantiates one independent reset controller per channel.
module wr_arria10_phy_rst_seq
  import wr_arria10_phy_pkg::*;
#(
  parameter int unsigned g_num_channels        = 1,       // 1..8
  parameter int unsigned g_analog_rst_cycles   = 100,
  parameter int unsigned g_digital_rst_cycles  = 50,
  parameter int unsigned g_ltd_stable_cycles   = 1000,
  parameter int unsigned g_lock_timeout_cycles = 100000
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          pll_locked_i,
  input  logic [g_num_channels-1:0]     tx_cal_busy_i,
  input  logic [g_num_channels-1:0]     rx_cal_busy_i,
  input  logic [g_num_channels-1:0]     rx_is_lockedtoref_i,
  input  logic [g_num_channels-1:0]     rx_is_lockedtodata_i,
  input  logic [g_num_channels-1:0]     chan_rst_i,
  output logic [g_num_channels-1:0]     tx_analogreset_o,
  output logic [g_num_channels-1:0]     tx_digitalreset_o,
  output logic [g_num_channels-1:0]     rx_analogreset_o,
  output logic [g_num_channels-1:0]     rx_digitalreset_o,
  output logic [g_num_channels-1:0]     rx_set_locktoref_o,
  output logic [g_num_channels-1:0]     rx_set_locktodata_o,
  output logic [g_num_channels-1:0]     tx_ready_o,
  output logic [g_num_channels-1:0]     rx_ready_o,
  output logic [8*g_num_channels-1:0]   rx_relock_cnt_o
);

  logic [1:0] pll_sync_q;
  logic       pll_locked_s;

  // Two-flop synchronizer for the PLL lock shared by all channels.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) pll_sync_q <= '0;
    else          pll_sync_q <= {pll_sync_q[0], pll_locked_i};
  end

  assign pll_locked_s = pll_sync_q[1];

  for (genvar i = 0; i < g_num_channels; i++) begin : g_chan
    wr_arria10_phy_rst_chan #(
      .g_analog_rst_cycles   (g_analog_rst_cycles),
      .g_digital_rst_cycles  (g_digital_rst_cycles),
      .g_ltd_stable_cycles   (g_ltd_stable_cycles),
      .g_lock_timeout_cycles (g_lock_timeout_cycles)
    ) u_chan (
      .clk_i              (clk_i),
      .rst_n_i            (rst_n_i),
      .pll_locked         (pll_locked_s),
      .tx_cal_busy        (tx_cal_busy_i[i]),
      .rx_cal_busy        (rx_cal_busy_i[i]),
      .rx_is_lockedtoref  (rx_is_lockedtoref_i[i]),
      .rx_is_lockedtodata (rx_is_lockedtodata_i[i]),
      .chan_rst           (chan_rst_i[i]),
      .tx_analogreset     (tx_analogreset_o[i]),
      .tx_digitalreset    (tx_digitalreset_o[i]),
      .rx_analogreset     (rx_analogreset_o[i]),
      .rx_digitalreset    (rx_digitalreset_o[i]),
      .rx_set_locktoref   (rx_set_locktoref_o[i]),
      .rx_set_locktodata  (rx_set_locktodata_o[i]),
      .tx_ready           (tx_ready_o[i]),
      .rx_ready           (rx_ready_o[i]),
      .rx_relock_cnt      (rx_relock_cnt_o[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_wr_arria10_phy_rst_seq.sv
// Scoreboard bench for wr_arria10_phy_rst_seq (analog 8, digital 4,
// LTD stable 16, timeout 64, two channels). Directed stimulus pushes the
// expected output changes (cycle, value) per channel/signal; a monitor pops
// and compares whenever tx_ready, rx_ready or a relock count changes.
//
// Timing reference: "base" is the cycle count at the negedge where the
// reset/soft reset is released, so base+1 is the first running edge.
//   TX: RST edges 1..8 -> WAIT at 8, DIG at 9, READY at 13.
//   RX: RST -> CAL at 8, LTR at 9, LTD at 10, DIG at 26, READY at 30.
//   Input changes made at negedge n are seen by the FSMs at edge n+3.
module tb_wr_arria10_phy_rst_seq;

  localparam int N = 2;
  localparam int K_TX = 0;
  localparam int K_RX = 1;
  localparam int K_RL = 2;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic           pll_locked_i;
  logic [N-1:0]   tx_cal_busy_i;
  logic [N-1:0]   rx_cal_busy_i;
  logic [N-1:0]   rx_is_lockedtoref_i;
  logic [N-1:0]   rx_is_lockedtodata_i;
  logic [N-1:0]   chan_rst_i;
  logic [N-1:0]   tx_analogreset_o;
  logic [N-1:0]   tx_digitalreset_o;
  logic [N-1:0]   rx_analogreset_o;
  logic [N-1:0]   rx_digitalreset_o;
  logic [N-1:0]   rx_set_locktoref_o;
  logic [N-1:0]   rx_set_locktodata_o;
  logic [N-1:0]   tx_ready_o;
  logic [N-1:0]   rx_ready_o;
  logic [8*N-1:0] rx_relock_cnt_o;

  wr_arria10_phy_rst_seq #(
    .g_num_channels        (N),
    .g_analog_rst_cycles   (8),
    .g_digital_rst_cycles  (4),
    .g_ltd_stable_cycles   (16),
    .g_lock_timeout_cycles (64)
  ) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .pll_locked_i         (pll_locked_i),
    .tx_cal_busy_i        (tx_cal_busy_i),
    .rx_cal_busy_i        (rx_cal_busy_i),
    .rx_is_lockedtoref_i  (rx_is_lockedtoref_i),
    .rx_is_lockedtodata_i (rx_is_lockedtodata_i),
    .chan_rst_i           (chan_rst_i),
    .tx_analogreset_o     (tx_analogreset_o),
    .tx_digitalreset_o    (tx_digitalreset_o),
    .rx_analogreset_o     (rx_analogreset_o),
    .rx_digitalreset_o    (rx_digitalreset_o),
    .rx_set_locktoref_o   (rx_set_locktoref_o),
    .rx_set_locktodata_o  (rx_set_locktodata_o),
    .tx_ready_o           (tx_ready_o),
    .rx_ready_o           (rx_ready_o),
    .rx_relock_cnt_o      (rx_relock_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } evt_t;

  evt_t exp_q [N*3][$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;

  function automatic string kind_name(input int k);
    case (k)
      K_TX:    return "tx_ready";
      K_RX:    return "rx_ready";
      default: return "rx_relock_cnt";
    endcase
  endfunction

  function automatic int observe(input int ch, input int k);
    case (k)
      K_TX:    return int'(tx_ready_o[ch]);
      K_RX:    return int'(rx_ready_o[ch]);
      default: return int'(rx_relock_cnt_o[8*ch +: 8]);
    endcase
  endfunction

  task automatic expect_evt(input int ch, input int k, input int at, input int val);
    evt_t e;
    e.cyc = at;
    e.val = val;
    exp_q[ch*3 + k].push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " tx_analogreset"},  64'(tx_analogreset_o),    64'h3);
    check({tag, " tx_digitalreset"}, 64'(tx_digitalreset_o),   64'h3);
    check({tag, " rx_analogreset"},  64'(rx_analogreset_o),    64'h3);
    check({tag, " rx_digitalreset"}, 64'(rx_digitalreset_o),   64'h3);
    check({tag, " locktoref"},       64'(rx_set_locktoref_o),  64'h3);
    check({tag, " locktodata"},      64'(rx_set_locktodata_o), 64'h0);
    check({tag, " tx_ready"},        64'(tx_ready_o),          64'h0);
    check({tag, " rx_ready"},        64'(rx_ready_o),          64'h0);
    check({tag, " relock_cnt"},      64'(rx_relock_cnt_o),     64'h0);
  endtask

  // Monitor: every change on a watched output must match the oldest
  // expectation for that channel/signal, both in value and in cycle.
  initial begin
    int   prev [N*3];
    int   cur;
    int   idx;
    evt_t e;
    foreach (prev[i]) prev[i] = 0;
    forever begin
      @(negedge clk_i);
      for (int ch = 0; ch < N; ch++) begin
        for (int k = 0; k < 3; k++) begin
          idx = ch*3 + k;
          cur = observe(ch, k);
          if (mon_en && (cur != prev[idx])) begin
            vectors++;
            if (exp_q[idx].size() == 0) begin
              miscompares++;
              $display("FAIL unexpected %s ch%0d: got %0d at cycle %0d, required no change",
                       kind_name(k), ch, cur, cyc);
            end else begin
              e = exp_q[idx].pop_front();
              if ((e.cyc != cyc) || (e.val != cur)) begin
                miscompares++;
                $display("FAIL %s ch%0d: got %0d at cycle %0d, required %0d at cycle %0d",
                         kind_name(k), ch, cur, cyc, e.val, e.cyc);
              end
            end
          end
          prev[idx] = cur;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int t;
    int b;
    evt_t e;

    rst_n_i              = 1'b0;
    pll_locked_i         = 1'b1;
    tx_cal_busy_i        = '0;
    rx_cal_busy_i        = '0;
    rx_is_lockedtoref_i  = '1;
    rx_is_lockedtodata_i = '1;
    chan_rst_i           = '0;
    repeat (3) @(negedge clk_i);
    check_reset_state("reset");
    mon_en = 1'b1;

    // Release with all locks good: full bring-up on both channels.
    t = cyc;
    rst_n_i = 1'b1;
    for (int ch = 0; ch < N; ch++) begin
      expect_evt(ch, K_TX, t + 13, 1);
      expect_evt(ch, K_RX, t + 30, 1);
    end
    wait_until(t + 8);
    check("tx_analog in WAIT", 64'(tx_analogreset_o), 64'h3);
    check("rx_analog in CAL",  64'(rx_analogreset_o), 64'h3);
    wait_until(t + 9);
    check("tx_analog released", 64'(tx_analogreset_o),   64'h0);
    check("tx_digital in DIG",  64'(tx_digitalreset_o),  64'h3);
    check("rx_analog released", 64'(rx_analogreset_o),   64'h0);
    check("locktoref in LTR",   64'(rx_set_locktoref_o), 64'h3);
    wait_until(t + 10);
    check("locktoref in LTD",   64'(rx_set_locktoref_o),  64'h0);
    check("locktodata in LTD",  64'(rx_set_locktodata_o), 64'h3);
    wait_until(t + 29);
    check("rx_digital in DIG",  64'(rx_digitalreset_o), 64'h3);
    wait_until(t + 30);
    check("rx_digital released", 64'(rx_digitalreset_o), 64'h0);
    wait_until(t + 40);

    // Soft reset both channels; one-cycle lockedtodata glitch on ch0 when
    // its stability count is 10 delays only ch0 rx_ready by 11 cycles.
    t = cyc;
    chan_rst_i = '1;
    for (int ch = 0; ch < N; ch++) begin
      expect_evt(ch, K_TX, t + 1, 0);
      expect_evt(ch, K_RX, t + 1, 0);
    end
    wait_until(t + 1);
    check("soft reset tx_analog", 64'(tx_analogreset_o), 64'h3);
    wait_until(t + 2);
    chan_rst_i = '0;
    b = t + 2;
    expect_evt(0, K_TX, b + 13, 1);
    expect_evt(1, K_TX, b + 13, 1);
    expect_evt(1, K_RX, b + 30, 1);
    expect_evt(0, K_RX, b + 41, 1);
    wait_until(b + 18);
    rx_is_lockedtodata_i[0] = 1'b0;
    wait_until(b + 19);
    rx_is_lockedtodata_i[0] = 1'b1;
    wait_until(b + 35);
    check("glitch rx_ready split", 64'(rx_ready_o), 64'h2);
    wait_until(b + 50);

    // ch0 lockedtoref stuck low: restart every 64 cycles in LTR (73-cycle
    // loop including RST and CAL), relock count 1,2,3, then recover.
    t = cyc;
    rx_is_lockedtoref_i[0] = 1'b0;
    chan_rst_i = 2'b01;
    expect_evt(0, K_TX, t + 1, 0);
    expect_evt(0, K_RX, t + 1, 0);
    wait_until(t + 2);
    chan_rst_i = '0;
    b = t + 2;
    expect_evt(0, K_TX, b + 13, 1);
    expect_evt(0, K_RL, b + 73, 1);
    expect_evt(0, K_RL, b + 146, 2);
    expect_evt(0, K_RL, b + 219, 3);
    expect_evt(0, K_RX, b + 249, 1);
    wait_until(b + 72);
    check("ltr wait analog", 64'(rx_analogreset_o), 64'h0);
    wait_until(b + 73);
    check("ltr timeout analog", 64'(rx_analogreset_o), 64'h1);
    wait_until(b + 222);
    rx_is_lockedtoref_i[0] = 1'b1;
    wait_until(b + 260);

    // ch1 loses data lock in READY: three cycles to drop, counter +1.
    t = cyc;
    rx_is_lockedtodata_i[1] = 1'b0;
    expect_evt(1, K_RX, t + 3, 0);
    expect_evt(1, K_RL, t + 3, 1);
    expect_evt(1, K_RX, t + 33, 1);
    wait_until(t + 2);
    check("ltd drop digital early", 64'(rx_digitalreset_o), 64'h0);
    wait_until(t + 3);
    check("ltd drop digital", 64'(rx_digitalreset_o), 64'h2);
    check("ltd drop ready",   64'(rx_ready_o),        64'h1);
    wait_until(t + 4);
    rx_is_lockedtodata_i[1] = 1'b1;
    wait_until(t + 45);

    // One-cycle PLL lock loss resequences TX of both channels only.
    t = cyc;
    pll_locked_i = 1'b0;
    for (int ch = 0; ch < N; ch++) begin
      expect_evt(ch, K_TX, t + 3, 0);
      expect_evt(ch, K_TX, t + 16, 1);
    end
    wait_until(t + 1);
    pll_locked_i = 1'b1;
    wait_until(t + 25);

    // Soft reset pulse on ch1 only; relock counts unchanged.
    t = cyc;
    chan_rst_i = 2'b10;
    expect_evt(1, K_TX, t + 1, 0);
    expect_evt(1, K_RX, t + 1, 0);
    wait_until(t + 1);
    chan_rst_i = '0;
    b = t + 1;
    expect_evt(1, K_TX, b + 13, 1);
    expect_evt(1, K_RX, b + 30, 1);
    wait_until(b + 40);
    check("relock after soft reset", 64'(rx_relock_cnt_o), 64'h0103);

    // ch0 calibration stuck busy: CAL timeout every 72 cycles; 300
    // timeouts saturate the count (already 3) at 255.
    t = cyc;
    rx_cal_busy_i[0] = 1'b1;
    chan_rst_i = 2'b01;
    expect_evt(0, K_TX, t + 1, 0);
    expect_evt(0, K_RX, t + 1, 0);
    wait_until(t + 1);
    chan_rst_i = '0;
    b = t + 1;
    expect_evt(0, K_TX, b + 13, 1);
    for (int i = 1; i <= 252; i++) expect_evt(0, K_RL, b + 72*i, 3 + i);
    wait_until(b + 72*300 + 2);
    check("relock saturated", 64'(rx_relock_cnt_o), 64'h01FF);

    // Reset in the middle of ch0's sequence.
    t = cyc;
    rst_n_i = 1'b0;
    expect_evt(0, K_TX, t + 1, 0);
    expect_evt(1, K_TX, t + 1, 0);
    expect_evt(1, K_RX, t + 1, 0);
    expect_evt(0, K_RL, t + 1, 0);
    expect_evt(1, K_RL, t + 1, 0);
    wait_until(t + 1);
    check_reset_state("mid reset");
    wait_until(t + 3);
    mon_en = 1'b0;

    // Any expectation still queued never happened.
    for (int q = 0; q < N*3; q++) begin
      while (exp_q[q].size() > 0) begin
        e = exp_q[q].pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing %s ch%0d: got no change, required %0d at cycle %0d",
                 kind_name(q % 3), q / 3, e.val, e.cyc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
